rr_mem_arbiter_n: RTL and testbench
===================================

// Module: rr_mem_arbiter_n
// PURPOSE
// Parametrised round-robin arbiter for N masters sharing one memory port.
// Adds a valid/ready memory handshake, a per-grant beat quantum, a read-return master ID and a read timeout.
// Sits between the master agents and the single memory/slave model.
// Generalises the fixed 4-master arbiter to N masters.
// PARAMETERS
// NUM_MASTERS  4   number of requesting masters (>=2)
// ADDR_W       32  address width
// DATA_W       32  write/read data width
// MAX_BEATS    4   max accepted transfers per grant before forced rotation (>=1)
// RD_TIMEOUT   64  max WAIT_RD cycles without rdata_ack before abort (>=2)
// PORTS
// clk              in   1                   rising-edge clock
// reset            in   1                   synchronous, active-high reset
// REQ              in   NUM_MASTERS         per-master request, level
// GNT              out  NUM_MASTERS         one-hot grant, or all-zero
// m_addr           in   NUM_MASTERS*ADDR_W  packed per-master address (master i at [i*ADDR_W +: ADDR_W])
// m_wdata          in   NUM_MASTERS*DATA_W  packed per-master write data
// m_write          in   NUM_MASTERS         1=write, 0=read
// mem_valid        out  1                   command valid to memory
// mem_ready        in   1                   memory accepts command
// mem_addr         out  ADDR_W              owner's address
// mem_wdata        out  DATA_W              owner's write data
// mem_write        out  1                   owner's write flag
// rdata            in   DATA_W              read data from memory
// rdata_ack        in   1                   read data valid
// slave_rdata      out  DATA_W              = rdata (combinational pass-through)
// slave_rdata_ack  out  1                   rdata_ack && state==WAIT_RD
// slave_rdata_id   out  $clog2(NUM_MASTERS) owner index, valid with slave_rdata_ack
// rd_timeout_err   out  1                   one-cycle pulse on read abort
// BEHAVIOUR
// - Reset (sync, high): state=IDLE, GNT=0, mem_valid=0, ptr=NUM_MASTERS-1 (master 0 wins first), beat_cnt=0, wait_cnt=0, rd_timeout_err=0.
// - States:
//   - IDLE: GNT=0, mem_valid=0.
//   - GRANT: mem_valid=1; mem_* = owner's m_* fields (combinational mux).
//   - WAIT_RD: mem_valid=0; GNT holds the owner.
// - Arbitration function: pick the first i with REQ[i]=1, scanning ptr+1, ptr+2, ... mod N. Winner becomes owner; ptr<=winner; beat_cnt<=0.
// - IDLE -> GRANT: REQ!=0 at edge t gives GNT one-hot from t+1. Latency is 1 cycle.
// - GRANT, owner REQ low with no handshake: release.
// - GRANT, mem_valid&&mem_ready, write: beat_cnt++. Stay if REQ[owner] and beat_cnt+1<MAX_BEATS; else release.
// - GRANT, mem_valid&&mem_ready, read: -> WAIT_RD, wait_cnt<=0.
// - WAIT_RD:
//   - rdata_ack=1: slave_rdata_ack=1, beat_cnt++. Then apply the same stay/release rule as for writes, returning to GRANT if staying.
//   - REQ[owner] drop: ignored while waiting.
//   - No ack: wait_cnt++. If wait_cnt==RD_TIMEOUT-1 and no ack, release; rd_timeout_err=1 (registered) on the next cycle only.
// - Release: re-arbitrate in the same cycle, with ptr=owner so the owner has lowest priority.
//   - Any REQ: next state GRANT with the new owner, no idle bubble.
//   - No REQ: IDLE.
//   - Sole requester: may regain the grant immediately with a fresh quantum.
// - Backpressure: while mem_valid&&!mem_ready, owner and GNT hold. Masters must hold m_* stable while REQ&&GNT.
// - rdata_ack outside WAIT_RD: ignored; slave_rdata_ack=0, no state change.
// - Reset mid-transfer: aborts; the next cycle follows reset values. A late rdata_ack is ignored.
// - GNT is always one-hot or zero; it never changes while mem_valid&&!mem_ready.
// TESTING
// - Reset held 2 cycles with REQ=4'hF -> GNT=0, mem_valid=0. First cycle after reset low: GNT=4'b0001.
// - MAX_BEATS=2, REQ=4'hF all writes, mem_ready=1 -> accepted owners 0,0,1,1,2,2,3,3,0, with no GNT=0 cycle between.
// - Master 2 read, rdata_ack 5 cycles later, rdata=32'hDEADBEEF:
//   - GNT=4'b0100 held through the wait, with mem_valid=0.
//   - slave_rdata_ack=1, slave_rdata_id=2, slave_rdata=32'hDEADBEEF.
// - RD_TIMEOUT=16, master 1 read, no ack, REQ[3]=1 -> after 16 wait cycles GNT=4'b1000 and rd_timeout_err high for exactly 1 cycle.
// - mem_ready=0 for 3 cycles on a master-0 write, addr=32'h100 -> mem_addr=32'h100, GNT=4'b0001 stable, accept on 4th cycle.
// - Reset asserted in WAIT_RD, ack 2 cycles later -> GNT=0 after reset edge; slave_rdata_ack stays 0.

Source files
------------

// File: rtl/rr_mem_arbiter_n_if.sv
// Bus bundle between N requesting masters, the round-robin arbiter and the shared memory port.
// The arbiter is the memory-bus master; the slave modport is the masters/memory side.
interface rr_mem_arbiter_n_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
);
    localparam int unsigned IdW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]        REQ;
    logic [NUM_MASTERS-1:0]        GNT;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_write;
    logic                          mem_valid;
    logic                          mem_ready;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic                          mem_write;
    logic [DATA_W-1:0]             rdata;
    logic                          rdata_ack;
    logic [DATA_W-1:0]             slave_rdata;
    logic                          slave_rdata_ack;
    logic [IdW-1:0]                slave_rdata_id;
    logic                          rd_timeout_err;

    modport master (
        input  REQ, m_addr, m_wdata, m_write, mem_ready, rdata, rdata_ack,
        output GNT, mem_valid, mem_addr, mem_wdata, mem_write,
        output slave_rdata, slave_rdata_ack, slave_rdata_id, rd_timeout_err
    );

    modport slave (
        output REQ, m_addr, m_wdata, m_write, mem_ready, rdata, rdata_ack,
        input  GNT, mem_valid, mem_addr, mem_wdata, mem_write,
        input  slave_rdata, slave_rdata_ack, slave_rdata_id, rd_timeout_err
    );
endinterface

// File: rtl/rr_mem_arbiter_n.sv
// Round-robin arbiter for N masters on one memory port: valid/ready command handshake,
// per-grant beat quantum, read-return master ID and read timeout abort.
module rr_mem_arbiter_n #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_BEATS   = 4,
    parameter int unsigned RD_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    rr_mem_arbiter_n_if.master bus
);
    localparam int unsigned IdxW  = $clog2(NUM_MASTERS);
    localparam int unsigned BeatW = $clog2(MAX_BEATS + 1);
    localparam int unsigned WaitW = $clog2(RD_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StGrant, StWaitRd} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d, win;
    logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d, beat_inc;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rd_timeout_err_q, rd_timeout_err_d;
    logic              any_req, owner_req, keep, release_own;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              own_write;
    logic [NUM_MASTERS-1:0] gnt;

    // ptr_q doubles as the owner while granted, so a release scan starts just past the owner.
    always_comb begin
        win     = ptr_q;
        any_req = 1'b0;
        for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
            if (!any_req && bus.REQ[IdxW'((int'(ptr_q) + k) % int'(NUM_MASTERS))]) begin
                win     = IdxW'((int'(ptr_q) + k) % int'(NUM_MASTERS));
                any_req = 1'b1;
            end
        end
    end

    assign owner_req = bus.REQ[ptr_q];
    assign beat_inc  = beat_cnt_q + 1'b1;
    assign keep      = owner_req && (beat_inc < BeatW'(MAX_BEATS));

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        beat_cnt_d       = beat_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        rd_timeout_err_d = 1'b0;
        release_own      = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d    = StGrant;
                    ptr_d      = win;
                    beat_cnt_d = '0;
                end
            end
            StGrant: begin
                if (bus.mem_ready) begin
                    if (own_write) begin
                        if (keep) beat_cnt_d = beat_inc;
                        else      release_own = 1'b1;
                    end else begin
                        state_d    = StWaitRd;
                        wait_cnt_d = '0;
                    end
                end else if (!owner_req) begin
                    release_own = 1'b1;
                end
            end
            StWaitRd: begin
                if (bus.rdata_ack) begin
                    if (keep) begin
                        state_d    = StGrant;
                        beat_cnt_d = beat_inc;
                    end else begin
                        release_own = 1'b1;
                    end
                end else if (wait_cnt_q == WaitW'(RD_TIMEOUT - 1)) begin
                    release_own      = 1'b1;
                    rd_timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Re-arbitrate in the releasing cycle so a waiting master gets the port with no bubble.
        if (release_own) begin
            if (any_req) begin
                state_d    = StGrant;
                ptr_d      = win;
                beat_cnt_d = '0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        own_addr  = '0;
        own_wdata = '0;
        own_write = 1'b0;
        gnt       = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (ptr_q == IdxW'(i)) begin
                own_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
                own_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
                own_write = bus.m_write[i];
                gnt[i]    = (state_q != StIdle);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            ptr_q            <= IdxW'(NUM_MASTERS - 1);
            beat_cnt_q       <= '0;
            wait_cnt_q       <= '0;
            rd_timeout_err_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            beat_cnt_q       <= beat_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            rd_timeout_err_q <= rd_timeout_err_d;
        end
    end

    assign bus.GNT             = gnt;
    assign bus.mem_valid       = (state_q == StGrant);
    assign bus.mem_addr        = own_addr;
    assign bus.mem_wdata       = own_wdata;
    assign bus.mem_write       = own_write;
    assign bus.slave_rdata     = bus.rdata;
    assign bus.slave_rdata_ack = bus.rdata_ack && (state_q == StWaitRd);
    assign bus.slave_rdata_id  = ptr_q;
    assign bus.rd_timeout_err  = rd_timeout_err_q;
endmodule

// File: tb/tb_rr_mem_arbiter_n.sv
// Directed bench for rr_mem_arbiter_n: reset, quantum rotation, backpressure, read return,
// read timeout and reset during a read wait.
module tb_rr_mem_arbiter_n;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_own [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    rr_mem_arbiter_n_if #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) bus ();

    rr_mem_arbiter_n #(
        .NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .MAX_BEATS(2), .RD_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.REQ       = 4'hF;
        bus.m_write   = 4'hF;
        bus.m_addr    = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
        bus.m_wdata   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        bus.mem_ready = 1'b1;
        bus.rdata     = '0;
        bus.rdata_ack = 1'b0;

        step();
        step();
        chk("reset_gnt", 64'(bus.GNT), 64'h0);
        chk("reset_valid", 64'(bus.mem_valid), 64'h0);
        chk("reset_err", 64'(bus.rd_timeout_err), 64'h0);

        reset = 1'b0;
        step();
        chk("first_gnt", 64'(bus.GNT), 64'h1);

        // MAX_BEATS=2 rotation, all writes, always ready
        for (int k = 0; k < 9; k++) begin
            chk("rot_gnt", 64'(bus.GNT), 64'(4'b0001 << exp_own[k]));
            chk("rot_valid", 64'(bus.mem_valid), 64'h1);
            chk("rot_addr", 64'(bus.mem_addr), 64'(32'h1000 + 32'(16 * exp_own[k])));
            step();
        end
        bus.REQ       = 4'h0;
        bus.mem_ready = 1'b0;
        step();
        chk("rot_idle", 64'(bus.GNT), 64'h0);

        // Backpressure on a master-0 write
        bus.m_addr[31:0] = 32'h100;
        bus.REQ          = 4'b0001;
        step();
        for (int c = 0; c < 3; c++) begin
            chk("bp_gnt", 64'(bus.GNT), 64'h1);
            chk("bp_valid", 64'(bus.mem_valid), 64'h1);
            chk("bp_addr", 64'(bus.mem_addr), 64'h100);
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("bp_gnt4", 64'(bus.GNT), 64'h1);
        bus.REQ             = 4'b0101;
        bus.m_write[2]      = 1'b0;
        bus.m_addr[95:64]   = 32'h200;
        step();
        chk("bp_stay", 64'(bus.GNT), 64'h1);
        step();
        chk("rd_gnt", 64'(bus.GNT), 64'h4);
        chk("rd_write", 64'(bus.mem_write), 64'h0);
        chk("rd_addr", 64'(bus.mem_addr), 64'h200);

        // Master 2 read with ack arriving after a wait
        step();
        bus.mem_ready = 1'b0;
        bus.REQ       = 4'b0100;
        chk("wait_gnt", 64'(bus.GNT), 64'h4);
        chk("wait_valid", 64'(bus.mem_valid), 64'h0);
        bus.REQ = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("wait_gnt", 64'(bus.GNT), 64'h4);
            chk("wait_valid", 64'(bus.mem_valid), 64'h0);
        end
        step();
        bus.rdata_ack = 1'b1;
        bus.rdata     = 32'hDEADBEEF;
        #1;
        chk("rd_ack", 64'(bus.slave_rdata_ack), 64'h1);
        chk("rd_id", 64'(bus.slave_rdata_id), 64'h2);
        chk("rd_data", 64'(bus.slave_rdata), 64'hDEADBEEF);
        step();
        bus.rdata_ack = 1'b0;
        chk("rd_done_idle", 64'(bus.GNT), 64'h0);

        // Stray ack outside a read wait
        bus.rdata_ack = 1'b1;
        #1;
        chk("stray_ack", 64'(bus.slave_rdata_ack), 64'h0);
        step();
        chk("stray_gnt", 64'(bus.GNT), 64'h0);
        bus.rdata_ack = 1'b0;

        // Master 1 read times out; master 3 waiting
        bus.m_write[1] = 1'b0;
        bus.REQ        = 4'b0010;
        bus.mem_ready  = 1'b1;
        step();
        chk("to_gnt1", 64'(bus.GNT), 64'h2);
        step();
        bus.REQ        = 4'b1010;
        bus.mem_ready  = 1'b0;
        bus.m_write[3] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("to_hold", 64'(bus.GNT), 64'h2);
            chk("to_noerr", 64'(bus.rd_timeout_err), 64'h0);
            step();
        end
        chk("to_gnt3", 64'(bus.GNT), 64'h8);
        chk("to_err", 64'(bus.rd_timeout_err), 64'h1);
        step();
        chk("to_err_clr", 64'(bus.rd_timeout_err), 64'h0);
        chk("to_gnt3_hold", 64'(bus.GNT), 64'h8);

        // Reset while master 3 waits for read data
        bus.m_write[3] = 1'b0;
        bus.mem_ready  = 1'b1;
        step();
        bus.REQ       = 4'b0000;
        bus.mem_ready = 1'b0;
        chk("rst_wait_gnt", 64'(bus.GNT), 64'h8);
        chk("rst_wait_valid", 64'(bus.mem_valid), 64'h0);
        reset = 1'b1;
        step();
        chk("rst_gnt", 64'(bus.GNT), 64'h0);
        reset = 1'b0;
        step();
        bus.rdata_ack = 1'b1;
        #1;
        chk("rst_late_ack", 64'(bus.slave_rdata_ack), 64'h0);
        chk("rst_late_gnt", 64'(bus.GNT), 64'h0);
        step();
        chk("rst_late_gnt2", 64'(bus.GNT), 64'h0);
        bus.rdata_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
